vexec_unit: RTL

Parametrised multi-cycle vector execution unit that runs VADD, SMUL and VDOT over N signed W-bit elements. It processes LANES elements per cycle, so the same RTL covers anything from a fully serial datapath to a fully parallel one. The unit sits between the register-file read ports and the write-back path of the vector core. The controller drives it with a start/done handshake and it reports overflow on V. It adds selectable saturation, which the previous per-operation units lacked.

---
 rtl/vexec_pkg.sv | 38 +++
 rtl/vexec_lane.sv | 36 +++
 rtl/vexec_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vexec_pkg.sv
// Shared types and the saturation helper for the vector execution unit.
package vexec_pkg;

  typedef enum logic [1:0] {
    OP_VADD = 2'b00,
    OP_VDOT = 2'b01,
    OP_SMUL = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned SATW = 64;

  typedef struct packed {
    logic signed [SATW-1:0] val;
    logic                   ovf;
  } sat_t;

  // Range-checks a sign-extended value against w signed bits; callers keep val[w-1:0].
  function automatic sat_t sat_w(input logic signed [SATW-1:0] x, input int unsigned w,
                                 input logic sat);
    sat_t r;
    logic signed [SATW-1:0] maxV;
    logic signed [SATW-1:0] minV;
    maxV  = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV  = -(64'sd1 <<< (w - 1));
    r.ovf = (x > maxV) || (x < minV);
    r.val = x;
    if (r.ovf && sat) r.val = x[SATW-1] ? minV : maxV;
    return r;
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// One element of the datapath: add or multiply, overflow detect, wrap/saturate select.
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter bit          SAT = 1'b0
) (
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   scalar,
  output logic [W-1:0]   res,
  output logic           ovf,
  output logic [2*W-1:0] prod
);

  logic [W-1:0]          mulB;
  logic signed [2*W-1:0] p;
  logic signed [W:0]     sum;
  sat_t                  s;
  logic                  unusedHi;

  // The multiplier is shared: SMUL scales by the scalar, VDOT multiplies by b.
  always_comb begin
    mulB = (op == OP_SMUL) ? scalar : b;
    p    = (2*W)'($signed(a)) * (2*W)'($signed(mulB));
    sum  = (W+1)'($signed(a)) + (W+1)'($signed(b));
    if (op == OP_SMUL) s = sat_w(SATW'(p), W, SAT);
    else               s = sat_w(SATW'(sum), W, SAT);
    res      = s.val[W-1:0];
    ovf      = s.ovf;
    prod     = p;
    unusedHi = ^s.val[SATW-1:W];
  end

endmodule

// File: rtl/vexec_unit.sv
// Multi-cycle VADD/SMUL/VDOT engine processing LANES elements per beat.
module vexec_unit
  import vexec_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned N     = 16,
  parameter int unsigned LANES = 4,
  parameter bit          SAT   = 1'b0
) (
  input  logic           Clk1,
  input  logic           Reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   scalar,
  input  logic [N*W-1:0] vecA,
  input  logic [N*W-1:0] vecB,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] result_v,
  output logic [W-1:0]   result_s,
  output logic           V
);

  localparam int unsigned BEATS = N / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ACCW  = 2 * W + $clog2(N);

  if (N % LANES != 0) begin : gBadLanes
    $error("vexec_unit: N must be a multiple of LANES");
  end
  if (ACCW > SATW) begin : gBadWidth
    $error("vexec_unit: accumulator wider than the saturation helper");
  end

  state_e                state, stateNext;
  op_e                   opR;
  logic [W-1:0]          scalarR;
  logic [N*W-1:0]        aR, bR;
  logic [BW-1:0]         beat;
  logic signed [ACCW-1:0] acc, accNext, beatSum;
  logic [31:0]           baseIdx;
  logic                  lastBeat;
  sat_t                  accSat;
  logic                  unusedAcc;

  logic [W-1:0]          laneA [LANES];
  logic [W-1:0]          laneB [LANES];
  logic [W-1:0]          laneRes [LANES];
  logic                  laneOvf [LANES];
  logic signed [2*W-1:0] laneProd [LANES];

  always_comb begin
    baseIdx  = LANES * 32'(beat);
    lastBeat = (beat == BW'(BEATS - 1));
    for (int unsigned l = 0; l < LANES; l++) begin
      laneA[l] = aR[(baseIdx + l) * W +: W];
      laneB[l] = bR[(baseIdx + l) * W +: W];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    vexec_lane #(.W(W), .SAT(SAT)) uLane (
      .op    (opR),
      .a     (laneA[g]),
      .b     (laneB[g]),
      .scalar(scalarR),
      .res   (laneRes[g]),
      .ovf   (laneOvf[g]),
      .prod  (laneProd[g])
    );
  end

  // Products are sign-extended to the full accumulator width, so nothing overflows mid-sum.
  always_comb begin
    beatSum = '0;
    for (int unsigned l = 0; l < LANES; l++) beatSum += ACCW'(laneProd[l]);
    accNext   = acc + beatSum;
    accSat    = sat_w(SATW'(accNext), W, SAT);
    unusedAcc = ^accSat.val[SATW-1:W];
  end

  always_comb begin
    stateNext = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) stateNext = (op == OP_NOP) ? DONE : RUN;
      RUN:  if (lastBeat) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state    <= IDLE;
      opR      <= OP_VADD;
      scalarR  <= '0;
      aR       <= '0;
      bR       <= '0;
      beat     <= '0;
      acc      <= '0;
      V        <= 1'b0;
      result_v <= '0;
      result_s <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start) begin
            V <= 1'b0;
            if (op != OP_NOP) begin
              opR     <= op_e'(op);
              scalarR <= scalar;
              aR      <= vecA;
              bR      <= vecB;
              beat    <= '0;
              acc     <= '0;
            end
          end
        end
        RUN: begin
          beat <= lastBeat ? '0 : beat + 1'b1;
          if (opR == OP_VDOT) begin
            acc <= accNext;
            if (lastBeat) begin
              result_s <= accSat.val[W-1:0];
              V        <= accSat.ovf;
            end
          end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
              result_v[(baseIdx + l) * W +: W] <= laneRes[l];
              if (laneOvf[l]) V <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
